product_display_ctrl: RTL and testbench

- Controller that sequences display of a signed multiplier product on the board's 7-segment front end.
- On a start pulse it captures the two's-complement product and runs an iterative binary-to-BCD (shift/add-3) conversion, one bit per clock.
- It then holds the BCD digits and a sign flag, and scrolls a 3-digit visible window across them with left/right button presses.
- Sits between the multiplier result register and the seven-segment mux/decoder.

---
 rtl/product_display_ctrl.sv | 111 +++++++++++
 tb/tb_product_display_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/product_display_ctrl.sv
// product_display_ctrl: converts a signed product to sign + BCD and scrolls a digit window over it.
//   clk     : system clock, rising edge
//   flg     : synchronous active-high reset/clear
//   start   : one-cycle pulse, samples product and begins conversion
//   product : two's-complement product (W bits)
//   btnl    : debounced level, scroll toward more-significant digits
//   btnr    : debounced level, scroll toward less-significant digits
//   busy    : high while converting
//   done    : one-cycle pulse when bcd/sign are updated
//   sign    : 1 = last converted product was negative
//   bcd     : ND digits, digit 0 in [3:0]
//   pos     : window position, 0..ND-WIN
//   win     : WIN visible digits starting at digit pos
module product_display_ctrl #(
    parameter int W   = 16,
    parameter int ND  = 5,
    parameter int WIN = 3
) (
    input  logic              clk,
    input  logic              flg,
    input  logic              start,
    input  logic [W-1:0]      product,
    input  logic              btnl,
    input  logic              btnr,
    output logic              busy,
    output logic              done,
    output logic              sign,
    output logic [4*ND-1:0]   bcd,
    output logic [1:0]        pos,
    output logic [4*WIN-1:0]  win
);
    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;
    localparam int CW = $clog2(W);
    localparam logic [1:0] PMAX = 2'(ND - WIN);
    state_t          state_q;
    logic [W-1:0]    mag_q;
    logic [4*ND-1:0] field_q, field_d, adj, bcd_q, shifted;
    logic [CW-1:0]   cnt_q;
    logic            sign_nx_q, sign_q, busy_q, done_q, btnl_q, btnr_q;
    logic [1:0]      pos_q;
    logic            pl, pr;
    // Add-3 correction on every digit, then the shifted-in bit is the magnitude MSB.
    always_comb begin
        adj = field_q;
        for (int i = 0; i < ND; i++)
            adj[4*i +: 4] = field_q[4*i +: 4] >= 4'd5 ? field_q[4*i +: 4] + 4'd3 : field_q[4*i +: 4];
    end
    assign field_d = {adj[4*ND-2:0], mag_q[W-1]};
    assign pl      = btnl & ~btnl_q;
    assign pr      = btnr & ~btnr_q;
    assign shifted = bcd_q >> {pos_q, 2'b00};
    assign win     = shifted[4*WIN-1:0];
    assign busy    = busy_q;
    assign done    = done_q;
    assign sign    = sign_q;
    assign bcd     = bcd_q;
    assign pos     = pos_q;
    always_ff @(posedge clk) begin
        if (flg) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            sign_q    <= 1'b0;
            bcd_q     <= '0;
            pos_q     <= 2'd0;
            btnl_q    <= 1'b1;
            btnr_q    <= 1'b1;
            mag_q     <= '0;
            field_q   <= '0;
            cnt_q     <= '0;
            sign_nx_q <= 1'b0;
        end else begin
            btnl_q <= btnl;
            btnr_q <= btnr;
            case (state_q)
                IDLE: begin
                    if (pl && !pr && pos_q != PMAX)
                        pos_q <= pos_q + 2'd1;
                    else if (pr && !pl && pos_q != 2'd0)
                        pos_q <= pos_q - 2'd1;
                    if (start) begin
                        // Negating at W bits maps -2^(W-1) onto 2^(W-1) as unsigned.
                        mag_q     <= product[W-1] ? -product : product;
                        sign_nx_q <= product[W-1];
                        field_q   <= '0;
                        cnt_q     <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= CONV;
                    end
                end
                CONV: begin
                    {field_q, mag_q} <= {field_d, mag_q[W-2:0], 1'b0};
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(W - 1)) begin
                        bcd_q   <= field_d;
                        sign_q  <= sign_nx_q;
                        pos_q   <= 2'd0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_product_display_ctrl.sv
// tb_product_display_ctrl: directed and random checks of product_display_ctrl against a decimal model.
module tb_product_display_ctrl;
    logic        clk = 0, flg = 1, start = 0, btnl = 0, btnr = 0;
    logic [15:0] product = 0;
    logic        busy, done, sign;
    logic [19:0] bcd;
    logic [1:0]  pos;
    logic [11:0] win;
    int checks = 0, fails = 0;
    int mpos = 0;
    int unsigned cur_mag = 0;

    product_display_ctrl dut (
        .clk(clk), .flg(flg), .start(start), .product(product),
        .btnl(btnl), .btnr(btnr), .busy(busy), .done(done),
        .sign(sign), .bcd(bcd), .pos(pos), .win(win)
    );

    always #5 clk = ~clk;

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int unsigned magof(input logic [15:0] p);
        return p[15] ? 32'd65536 - 32'(p) : 32'(p);
    endfunction

    function automatic logic [3:0] dig(input int unsigned m, input int i);
        int unsigned v = m;
        for (int k = 0; k < i; k++) v = v / 10;
        return 4'(v % 10);
    endfunction

    function automatic logic [19:0] ref_bcd(input int unsigned m);
        logic [19:0] r;
        for (int i = 0; i < 5; i++) r[4*i +: 4] = dig(m, i);
        return r;
    endfunction

    function automatic logic [11:0] ref_win(input int unsigned m, input int p);
        return {dig(m, p + 2), dig(m, p + 1), dig(m, p)};
    endfunction

    // Pulse start, optionally re-pulse start mid-conversion, and check latency and result.
    task automatic run_conv(input logic [15:0] p, input bit restart);
        int cyc = 0;
        start = 1; product = p;
        step();
        start = 0; product = 16'($urandom);
        while (!done && cyc < 40) begin
            chk("busy_during_conv", busy, 1);
            if (restart && cyc == 5) start = 1;
            step();
            start = 0;
            cyc++;
        end
        cur_mag = magof(p);
        mpos = 0;
        chk("latency", cyc, 16);
        chk("done_pulse", done, 1);
        chk("busy_at_done", busy, 0);
        chk("sign", sign, p[15]);
        chk("bcd", bcd, ref_bcd(cur_mag));
        chk("pos_at_done", pos, 0);
        chk("win_at_done", win, ref_win(cur_mag, 0));
        step();
        chk("done_one_cycle", done, 0);
    endtask

    task automatic buttons(input bit l, input bit r, input string tag);
        btnl = l; btnr = r;
        step();
        if (l && !r) mpos = (mpos < 2) ? mpos + 1 : 2;
        if (r && !l) mpos = (mpos > 0) ? mpos - 1 : 0;
        chk(tag, pos, mpos);
        chk({tag, "_win"}, win, ref_win(cur_mag, mpos));
        btnl = 0; btnr = 0;
        step();
    endtask

    initial begin
        int seen;
        step(2);
        flg = 0;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sign", sign, 0);
        chk("rst_bcd", bcd, 0);
        chk("rst_pos", pos, 0);

        run_conv(16'hFF38, 0);
        chk("neg200_bcd_const", bcd, 20'h00200);

        run_conv(16'h7FFF, 0);
        chk("max_bcd_const", bcd, 20'h32767);
        buttons(1, 0, "l1");
        chk("l1_win_const", win, 12'h276);
        buttons(1, 0, "l2");
        chk("l2_win_const", win, 12'h327);
        buttons(1, 0, "l_sat");
        buttons(0, 1, "r1");
        buttons(0, 1, "r0");
        buttons(0, 1, "r_sat");

        run_conv(16'h8000, 1);
        chk("min_bcd_const", bcd, 20'h32768);
        seen = 0;
        repeat (25) begin step(); if (done) seen++; end
        chk("no_second_done", seen, 0);

        start = 1; product = 16'h1234;
        step();
        start = 0;
        step(8);
        flg = 1;
        step();
        flg = 0;
        chk("abort_busy", busy, 0);
        chk("abort_bcd", bcd, 0);
        chk("abort_sign", sign, 0);
        chk("abort_pos", pos, 0);
        seen = 0;
        repeat (30) begin step(); if (done) seen++; end
        chk("abort_no_done", seen, 0);
        cur_mag = 0; mpos = 0;

        run_conv(16'd4321, 0);
        buttons(1, 0, "to1");
        buttons(1, 1, "both");

        btnl = 1;
        step();
        flg = 1;
        step();
        flg = 0;
        step(3);
        chk("held_thru_reset", pos, 0);
        btnl = 0;
        step();
        btnl = 1;
        step(50);
        chk("held_50", pos, 1);
        btnl = 0;
        step();

        start = 1; product = 16'd0;
        step();
        start = 0;
        step(3);
        btnl = 1;
        step();
        chk("press_in_conv", pos, 1);
        btnl = 0;
        seen = 0;
        while (!done && seen < 40) begin step(); seen++; end
        chk("zero_latency", seen + 4, 16);
        chk("zero_pos", pos, 0);
        chk("zero_sign", sign, 0);
        chk("zero_bcd", bcd, 0);
        step();

        for (int n = 0; n < 15; n++) begin
            run_conv(16'($urandom), 0);
            for (int k = 0; k < 5; k++)
                buttons(1'($urandom), 1'($urandom), "rand_btn");
        end

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
